cfg_image_sequencer: RTL

CFG_IMAGE_SEQUENCER -- requirements
Module: cfg_image_sequencer

---
 rtl/cfg_image_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cfg_image_sequencer.sv
// Configuration image sequencer: reads the boot pointer from the flash
// controller, hands flash to the PFL, pulses reconfigure/reset, supervises
// CONF_DONE/nSTATUS with retries and falls back to the factory image (page 0).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// BOOT_WAIT | wait for the initial configuration to report CONF_DONE
// READ_PTR  | flash controller owns flash, reading the boot pointer
// HANDBACK  | one guard cycle before the PFL takes the flash back
// RECONF    | pfl_nreconfigure held low for CFG_CYC cycles
// PFL_RST   | pfl_nreset held low for RST_CYC cycles
// WAIT_DONE | wait for CONF_DONE; nSTATUS low or timeout is a failure
// IDLE      | configured; accepts next_req / sel_valid
// FAIL      | factory image failed too; terminal until reset
module cfg_image_sequencer #(
    parameter int NUM_IMAGES = 3,
    parameter int PGM_W      = 3,
    parameter int CFG_CYC    = 16777215,
    parameter int RST_CYC    = 16777215,
    parameter int TMO_CYC    = 268435455,
    parameter int MAX_RETRY  = 2
) (
    input  logic             clkin_max_100,
    input  logic             sys_resetn,
    input  logic             fpga_conf_done,
    input  logic             fpga_statusn,
    input  logic             next_req,
    input  logic             sel_valid,
    input  logic [PGM_W-1:0] sel_page,
    input  logic             rd_done,
    input  logic [PGM_W-1:0] rd_page,
    output logic             pfl_flash_access,
    output logic             fl_req,
    output logic [PGM_W-1:0] fpga_pgm,
    output logic             pfl_nreconfigure,
    output logic             pfl_nreset,
    output logic             cfg_error,
    output logic [3:0]       state_dbg
);

    localparam int CNT_MAX_VAL = (CFG_CYC > RST_CYC)
                               ? ((CFG_CYC > TMO_CYC) ? CFG_CYC : TMO_CYC)
                               : ((RST_CYC > TMO_CYC) ? RST_CYC : TMO_CYC);
    localparam int CNT_W = $clog2(CNT_MAX_VAL + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Terminal counts: the counter starts at 0 on state entry, so a state
    // lasting N cycles leaves when the counter reads N-1.
    localparam logic [CNT_W-1:0] CFG_TC  = CNT_W'(CFG_CYC - 1);
    localparam logic [CNT_W-1:0] RST_TC  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_TC  = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX_VAL);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    localparam logic [PGM_W:0]   NUM_IMG = (PGM_W + 1)'(NUM_IMAGES);
    localparam logic [PGM_W-1:0] LAST_IMG = PGM_W'(NUM_IMAGES - 1);

    typedef enum logic [3:0] {
        S_BOOT_WAIT = 4'd0,
        S_READ_PTR  = 4'd1,
        S_HANDBACK  = 4'd2,
        S_RECONF    = 4'd3,
        S_PFL_RST   = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_IDLE      = 4'd6,
        S_FAIL      = 4'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [PGM_W-1:0] pgm_q, pgm_d;
    logic             err_q, err_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [1:0]       conf_sync_q, conf_sync_d;
    logic [1:0]       stat_sync_q, stat_sync_d;
    logic             conf_done_s, statusn_s;
    logic             sel_ok, rd_ok;

    assign conf_done_s = conf_sync_q[1];
    assign statusn_s   = stat_sync_q[1];
    assign sel_ok      = {1'b0, sel_page} < NUM_IMG;
    assign rd_ok       = {1'b0, rd_page} < NUM_IMG;
    assign fpga_pgm    = pgm_q;
    assign cfg_error   = err_q;
    assign state_dbg   = state_q;

    // Next-state, retry/fallback policy and state-decoded outputs.
    always_comb begin
        state_d          = state_q;
        pgm_d            = pgm_q;
        err_d            = err_q;
        retry_d          = retry_q;
        conf_sync_d      = {conf_sync_q[0], fpga_conf_done};
        stat_sync_d      = {stat_sync_q[0], fpga_statusn};
        cnt_inc          = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);
        pfl_flash_access = 1'b1;
        fl_req           = 1'b1;
        pfl_nreconfigure = 1'b1;
        pfl_nreset       = 1'b1;
        case (state_q)
            S_BOOT_WAIT: begin
                if (conf_done_s) begin
                    state_d = S_READ_PTR;
                end else if (cnt_q == TMO_TC) begin
                    state_d = S_FAIL;
                    err_d   = 1'b1;
                end
            end
            S_READ_PTR: begin
                pfl_flash_access = 1'b0;
                fl_req           = 1'b0;
                if (rd_done) begin
                    pgm_d   = rd_ok ? rd_page : '0;
                    state_d = S_HANDBACK;
                end
            end
            S_HANDBACK: begin
                pfl_flash_access = 1'b0;
                state_d          = S_RECONF;
            end
            S_RECONF: begin
                pfl_nreconfigure = 1'b0;
                if (cnt_q == CFG_TC) state_d = S_PFL_RST;
            end
            S_PFL_RST: begin
                pfl_nreset = 1'b0;
                if (cnt_q == RST_TC) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (conf_done_s) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end else if (!statusn_s || (cnt_q == TMO_TC)) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_RECONF;
                    end else if (pgm_q != '0) begin
                        pgm_d   = '0;
                        err_d   = 1'b1;
                        retry_d = '0;
                        state_d = S_RECONF;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_IDLE: begin
                // sel_valid wins over next_req even when its page is out of range
                if (sel_valid) begin
                    if (sel_ok) begin
                        pgm_d   = sel_page;
                        state_d = S_RECONF;
                    end
                end else if (next_req) begin
                    pgm_d   = (pgm_q == LAST_IMG) ? '0 : pgm_q + PGM_W'(1);
                    state_d = S_RECONF;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_BOOT_WAIT;
            end
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_inc;
    end

    // State, counters and synchronisers; reset aborts any pulse in progress.
    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q     <= S_BOOT_WAIT;
            cnt_q       <= '0;
            pgm_q       <= '0;
            err_q       <= 1'b0;
            retry_q     <= '0;
            conf_sync_q <= '0;
            stat_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pgm_q       <= pgm_d;
            err_q       <= err_d;
            retry_q     <= retry_d;
            conf_sync_q <= conf_sync_d;
            stat_sync_q <= stat_sync_d;
        end
    end

endmodule
